// File: rtl/smpl_ram.sv
// Simple dual-port sample store: one write port, one read port with a registered output.
// Reads return the contents from before a same-cycle write to the same address.
module smpl_ram #(
   parameter int BW     = 16,
   parameter int LGFLEN = 10
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [LGFLEN-1:0] i_waddr,
   input  logic [BW-1:0]     i_wdata,
   input  logic [LGFLEN-1:0] i_raddr,
   output logic [BW-1:0]     o_rdata
);

   localparam int FLEN = 1 << LGFLEN;

   logic [BW-1:0] r_mem [0:FLEN-1];
   logic [BW-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we)
         r_mem[i_waddr] <= i_wdata;
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/smpl_fifo_thr.sv
// Show-ahead sample FIFO with a fill-threshold flag and sticky overflow/underflow flags.
// Occupancy is tracked by a fill counter, so all FLEN entries are usable.
module smpl_fifo_thr #(
   parameter int BW            = 16,
   parameter int LGFLEN        = 10,
   parameter bit OPT_OVERWRITE = 1'b0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr,
   input  logic [BW-1:0]     i_data,
   input  logic              i_rd,
   input  logic [LGFLEN:0]   i_thresh,
   input  logic              i_clr_err,
   output logic              o_empty_n,
   output logic [BW-1:0]     o_data,
   output logic [LGFLEN:0]   o_fill,
   output logic              o_full,
   output logic              o_thresh,
   output logic              o_ovfl,
   output logic              o_unfl
);

   localparam int              FLEN     = 1 << LGFLEN;
   localparam logic [LGFLEN:0] FILL_MAX = (LGFLEN+1)'(FLEN);
   localparam logic [LGFLEN:0] FILL_ONE = (LGFLEN+1)'(1);

   logic [LGFLEN-1:0] r_wr_ptr    = '0;
   logic [LGFLEN-1:0] r_rd_ptr    = '0;
   logic [LGFLEN:0]   r_fill      = '0;
   logic              r_full      = 1'b0;
   logic              r_empty_n   = 1'b0;
   logic              r_thresh    = 1'b0;
   logic              r_ovfl      = 1'b0;
   logic              r_unfl      = 1'b0;
   logic              r_byp_sel   = 1'b0;
   logic [BW-1:0]     r_byp_data  = '0;

   logic              w_wr_req;
   logic              w_rd_req;
   logic              w_empty;
   logic              w_full;
   logic              w_do_rd;
   logic              w_do_wr;
   logic              w_drop_oldest;
   logic              w_rd_adv;
   logic              w_ovfl_set;
   logic              w_unfl_set;
   logic              w_byp_hit;
   logic [LGFLEN:0]   w_fill_next;
   logic [LGFLEN-1:0] w_rd_ptr_next;
   logic [BW-1:0]     w_ram_q;

   // Accesses presented during the reset cycle are ignored.
   assign w_wr_req      = i_wr & ~i_rst;
   assign w_rd_req      = i_rd & ~i_rst;
   assign w_empty       = (r_fill == '0);
   assign w_full        = (r_fill == FILL_MAX);
   assign w_do_rd       = w_rd_req & ~w_empty;
   assign w_do_wr       = w_wr_req & (~w_full | w_do_rd | OPT_OVERWRITE);
   assign w_drop_oldest = w_wr_req & w_full & ~w_do_rd & OPT_OVERWRITE;
   assign w_rd_adv      = w_do_rd | w_drop_oldest;
   assign w_ovfl_set    = w_wr_req & w_full & ~w_do_rd;
   assign w_unfl_set    = w_rd_req & w_empty;
   assign w_rd_ptr_next = w_rd_adv ? r_rd_ptr + 1'b1 : r_rd_ptr;

   always_comb begin
      w_fill_next = r_fill;
      if (w_do_wr && !w_rd_adv)
         w_fill_next = r_fill + FILL_ONE;
      else if (!w_do_wr && w_rd_adv)
         w_fill_next = r_fill - FILL_ONE;
   end

   // The RAM reads the entry that will be oldest next cycle; a write landing on
   // that same address is not visible through the RAM yet, so it is bypassed.
   assign w_byp_hit = w_do_wr & (r_wr_ptr == w_rd_ptr_next);

   smpl_ram #(
      .BW     (BW),
      .LGFLEN (LGFLEN)
   ) u_ram (
      .i_clk   (i_clk),
      .i_we    (w_do_wr),
      .i_waddr (r_wr_ptr),
      .i_wdata (i_data),
      .i_raddr (w_rd_ptr_next),
      .o_rdata (w_ram_q)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_fill    <= '0;
         r_full    <= 1'b0;
         r_empty_n <= 1'b0;
         r_thresh  <= 1'b0;
         r_byp_sel <= 1'b0;
      end else begin
         if (w_do_wr)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         r_rd_ptr  <= w_rd_ptr_next;
         r_fill    <= w_fill_next;
         r_full    <= (w_fill_next == FILL_MAX);
         r_empty_n <= (w_fill_next != '0);
         r_thresh  <= (i_thresh != '0) && (w_fill_next >= i_thresh);
         r_byp_sel <= w_byp_hit;
      end
      if (w_byp_hit)
         r_byp_data <= i_data;
   end

   // A new error in the same cycle as a clear request leaves the flag set.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ovfl <= 1'b0;
         r_unfl <= 1'b0;
      end else begin
         if (w_ovfl_set)
            r_ovfl <= 1'b1;
         else if (i_clr_err)
            r_ovfl <= 1'b0;
         if (w_unfl_set)
            r_unfl <= 1'b1;
         else if (i_clr_err)
            r_unfl <= 1'b0;
      end
   end

   assign o_data    = r_byp_sel ? r_byp_data : w_ram_q;
   assign o_fill    = r_fill;
   assign o_full    = r_full;
   assign o_empty_n = r_empty_n;
   assign o_thresh  = r_thresh;
   assign o_ovfl    = r_ovfl;
   assign o_unfl    = r_unfl;

endmodule
